// File: rtl/control_unit_if.sv
// Bus between the control unit, its instruction ROM and the datapath.
// Master is the control unit; slave is the ROM/datapath side.
interface control_unit_if #(parameter int PC_W = 7);
  logic [15:0]     instr_data;
  logic [PC_W-1:0] pc_addr;
  logic [15:0]     ir;
  logic [3:0]      state;
  logic            halted;
  logic [7:0]      d_addr;
  logic            d_wr;
  logic            rf_s;
  logic [3:0]      rf_w_addr;
  logic            rf_w_en;
  logic [3:0]      rf_ra_addr;
  logic [3:0]      rf_rb_addr;
  logic [2:0]      alu_s0;
  logic            illegal;

  modport master (
    input  instr_data,
    output pc_addr, ir, state, halted, d_addr, d_wr, rf_s, rf_w_addr,
           rf_w_en, rf_ra_addr, rf_rb_addr, alu_s0, illegal
  );

  modport slave (
    output instr_data,
    input  pc_addr, ir, state, halted, d_addr, d_wr, rf_s, rf_w_addr,
           rf_w_en, rf_ra_addr, rf_rb_addr, alu_s0, illegal
  );
endinterface

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the six-instruction processor (Moore FSM).
// Define CU_ILLEGAL_TRAP_EN to trap opcodes 6-15 into Halt with Illegal set.
module control_unit #(
  parameter int PC_W = 7
) (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic [3:0]      opcode;

  assign opcode = bus.instr_data[15:12];

  // ROM data is only valid in Decode, so IR capture and PC advance happen on that exit edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        ir_q <= bus.instr_data;
        pc_q <= pc_q + 1'b1;
      end
    end
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (state_q == S_DECODE && opcode > 4'd5) begin
      illegal_q <= 1'b1;
    end
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'd0:    state_d = S_NOOP;
          4'd1:    state_d = S_STORE;
          4'd2:    state_d = S_LOAD_A;
          4'd3:    state_d = S_ADD;
          4'd4:    state_d = S_SUB;
          4'd5:    state_d = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
          default: state_d = S_HALT;
`else
          default: state_d = S_NOOP;
`endif
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  always_comb begin
    bus.d_addr     = 8'd0;
    bus.d_wr       = 1'b0;
    bus.rf_s       = 1'b0;
    bus.rf_w_addr  = 4'd0;
    bus.rf_w_en    = 1'b0;
    bus.rf_ra_addr = 4'd0;
    bus.rf_rb_addr = 4'd0;
    bus.alu_s0     = 3'd0;
    case (state_q)
      S_STORE: begin
        bus.d_addr     = ir_q[11:4];
        bus.rf_ra_addr = ir_q[3:0];
        bus.d_wr       = 1'b1;
      end
      S_LOAD_A: bus.d_addr = ir_q[11:4];
      S_LOAD_B: begin
        bus.d_addr    = ir_q[11:4];
        bus.rf_s      = 1'b1;
        bus.rf_w_addr = ir_q[3:0];
        bus.rf_w_en   = 1'b1;
      end
      S_ADD, S_SUB: begin
        bus.rf_ra_addr = ir_q[11:8];
        bus.rf_rb_addr = ir_q[7:4];
        bus.rf_w_addr  = ir_q[3:0];
        bus.rf_w_en    = 1'b1;
        bus.alu_s0     = (state_q == S_ADD) ? 3'd1 : 3'd2;
      end
      default: ;
    endcase
  end

  assign bus.pc_addr = pc_q;
  assign bus.ir      = ir_q;
  assign bus.state   = state_q;
  assign bus.halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed vector table, corner sequences and a
// random-program run against an instruction-level reference model.
module tb_control_unit;

  typedef struct packed {
    logic [3:0]  state;
    logic [6:0]  pc;
    logic [15:0] ir;
    logic        halted;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic        rf_s;
    logic [3:0]  rf_w_addr;
    logic        rf_w_en;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  alu;
    logic        illegal;
  } obs_t;

  typedef struct {
    string       name;
    logic [15:0] instr;
    int          cycles;
    int          nextState;
    obs_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] rom [128];
  int compared = 0;
  int mismatched = 0;

  control_unit_if #(.PC_W(7)) bus ();

  control_unit #(.PC_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous instruction ROM: data appears the cycle after the address is sampled
  always @(posedge clk) bus.instr_data <= rom[bus.pc_addr];

  // Instruction-level reference model state
  logic [6:0]  mPc;
  logic [15:0] mIr;
  bit          mHalt, mIll;
  obs_t        expQ[$];

  function automatic obs_t mkObs(int st, int pc, logic [15:0] ir, int hlt, int da, int dw,
                                 int rs, int wa, int we, int ra, int rb, int alu, int ill);
    obs_t o;
    o.state = 4'(st); o.pc = 7'(pc); o.ir = ir; o.halted = 1'(hlt);
    o.d_addr = 8'(da); o.d_wr = 1'(dw); o.rf_s = 1'(rs); o.rf_w_addr = 4'(wa);
    o.rf_w_en = 1'(we); o.ra = 4'(ra); o.rb = 4'(rb); o.alu = 3'(alu); o.illegal = 1'(ill);
    return o;
  endfunction

  function automatic obs_t sampleDut();
    obs_t o;
    o.state = bus.state; o.pc = bus.pc_addr; o.ir = bus.ir; o.halted = bus.halted;
    o.d_addr = bus.d_addr; o.d_wr = bus.d_wr; o.rf_s = bus.rf_s; o.rf_w_addr = bus.rf_w_addr;
    o.rf_w_en = bus.rf_w_en; o.ra = bus.rf_ra_addr; o.rb = bus.rf_rb_addr;
    o.alu = bus.alu_s0; o.illegal = bus.illegal;
    return o;
  endfunction

  // Push the per-cycle outputs of the next instruction (or one stalled Halt cycle)
  function automatic void modelStep();
    obs_t r;
    logic [15:0] w;
    int op;
    r = '0;
    if (mHalt) begin
      r.state = 4'd9; r.pc = mPc; r.ir = mIr; r.halted = 1'b1; r.illegal = mIll;
      expQ.push_back(r);
      return;
    end
    w = rom[mPc];
    r.pc = mPc; r.ir = mIr;
    r.state = 4'd1; expQ.push_back(r);
    r.state = 4'd2; expQ.push_back(r);
    mPc = mPc + 7'd1;
    mIr = w;
    op = int'(w[15:12]);
    r = '0; r.pc = mPc; r.ir = w;
    if (op == 0) begin
      r.state = 4'd3; expQ.push_back(r);
    end else if (op == 1) begin
      r.state = 4'd6; r.d_addr = w[11:4]; r.ra = w[3:0]; r.d_wr = 1'b1;
      expQ.push_back(r);
    end else if (op == 2) begin
      r.state = 4'd4; r.d_addr = w[11:4]; expQ.push_back(r);
      r.state = 4'd5; r.rf_s = 1'b1; r.rf_w_addr = w[3:0]; r.rf_w_en = 1'b1;
      expQ.push_back(r);
    end else if (op == 3 || op == 4) begin
      r.state = (op == 3) ? 4'd7 : 4'd8;
      r.ra = w[11:8]; r.rb = w[7:4]; r.rf_w_addr = w[3:0]; r.rf_w_en = 1'b1;
      r.alu = (op == 3) ? 3'd1 : 3'd2;
      expQ.push_back(r);
    end else if (op == 5) begin
      mHalt = 1'b1;
    end else begin
`ifdef CU_ILLEGAL_TRAP_EN
      mHalt = 1'b1; mIll = 1'b1;
`else
      r.state = 4'd3; expQ.push_back(r);
`endif
    end
  endfunction

  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input obs_t exp);
    obs_t act;
    act = sampleDut();
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got state=%0d pc=%0d raw=%h, required state=%0d pc=%0d raw=%h",
               name, act.state, act.pc, act, exp.state, exp.pc, exp);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    applyStimulus(2);
    checkOutput("reset_state", '0);
    rst = 1'b0;
  endtask

  task automatic clearRom();
    for (int a = 0; a < 128; a++) rom[a] = 16'h0000;
  endtask

  task automatic runProgram(input string name, input int cycles);
    applyReset();
    mPc = '0; mIr = '0; mHalt = 1'b0; mIll = 1'b0;
    expQ.delete();
    for (int c = 0; c < cycles; c++) begin
      applyStimulus(1);
      if (expQ.size() == 0) modelStep();
      checkOutput(name, expQ.pop_front());
    end
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"load",  16'h2053, 4, 1, mkObs(5, 1, 16'h2053, 0, 8'h05, 0, 1, 3, 1, 0, 0, 0, 0)});
    vecs.push_back('{"store", 16'h1123, 3, 1, mkObs(6, 1, 16'h1123, 0, 8'h12, 1, 0, 0, 0, 3, 0, 0, 0)});
    vecs.push_back('{"add",   16'h3124, 3, 1, mkObs(7, 1, 16'h3124, 0, 0, 0, 0, 4, 1, 1, 2, 1, 0)});
    vecs.push_back('{"sub",   16'h4124, 3, 1, mkObs(8, 1, 16'h4124, 0, 0, 0, 0, 4, 1, 1, 2, 2, 0)});
    vecs.push_back('{"noop",  16'h0000, 3, 1, mkObs(3, 1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"halt",  16'h5000, 3, 9, mkObs(9, 1, 16'h5000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
`ifdef CU_ILLEGAL_TRAP_EN
    vecs.push_back('{"illegal", 16'hA000, 3, 9, mkObs(9, 1, 16'hA000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
`else
    vecs.push_back('{"illegal", 16'hA000, 3, 1, mkObs(3, 1, 16'hA000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
`endif

    clearRom();
    bus.instr_data = 16'h0000;

    foreach (vecs[i]) begin
      clearRom();
      rom[0] = vecs[i].instr;
      applyReset();
      applyStimulus(1);
      checkValue({vecs[i].name, "_first_fetch_pc"}, int'(bus.pc_addr), 0);
      applyStimulus(vecs[i].cycles - 1);
      checkOutput({vecs[i].name, "_exec"}, vecs[i].exp);
      applyStimulus(1);
      checkValue({vecs[i].name, "_next_state"}, int'(bus.state), vecs[i].nextState);
    end

    // Reset asserted in the middle of LoadB must drop the write immediately
    clearRom();
    rom[0] = 16'h2053;
    applyReset();
    applyStimulus(4);
    checkValue("midload_wen_before", int'(bus.rf_w_en), 1);
    #2 rst = 1'b1;
    #1;
    checkValue("midload_state", int'(bus.state), 0);
    checkValue("midload_wen", int'(bus.rf_w_en), 0);
    checkValue("midload_pc", int'(bus.pc_addr), 0);
    checkValue("midload_ir", int'(bus.ir), 0);
    applyStimulus(1);
    rst = 1'b0;

    // All-NOOP ROM: 128th instruction wraps the PC from 127 back to 0
    clearRom();
    applyReset();
    applyStimulus(383);
    checkValue("wrap_pc_127", int'(bus.pc_addr), 127);
    applyStimulus(1);
    checkValue("wrap_pc_0", int'(bus.pc_addr), 0);

    // Halt after a few NOOPs stays frozen for well over 20 cycles
    clearRom();
    rom[5] = 16'h5000;
    runProgram("halt_freeze", 5 * 3 + 2 + 30);
    checkValue("halt_freeze_pc", int'(bus.pc_addr), 6);

    // Randomized programs against the reference model
    for (int p = 0; p < 4; p++) begin
      for (int a = 0; a < 128; a++) begin
        int r;
        logic [3:0] op;
        r = int'($urandom_range(0, 99));
        if (r < 90)      op = 4'($urandom_range(0, 4));
        else if (r < 95) op = 4'd5;
        else             op = 4'($urandom_range(6, 15));
        rom[a] = {op, 12'($urandom)};
      end
      runProgram("random", 250);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-sequencing controller for the six-instruction processor; sits directly upstream of the datapath and drives every datapath control input. Holds the program counter and instruction register, fetches 16-bit instructions from a synchronous instruction ROM, decodes them, and steps a Moore state machine through fetch/decode/execute. Datapath-facing outputs connect one-to-one to the datapath ports of the same names.

## Interface
- PC_W, default 7: program counter / instruction ROM address width (128 words).
- Clock  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high; forces state Init, PC=0, IR=0.
- Instr_Data  input  16  instruction ROM read data; valid the cycle after PC_Addr is sampled.
- PC_Addr  output  PC_W  instruction ROM address (current PC).
- IR  output  16  instruction register contents.
- State  output  4  encoded current state, for debug/display.
- Halted  output  1  high while in state Halt.
- D_Addr  output  8  data memory address.
- D_Wr  output  1  data memory write enable.
- RF_s  output  1  register-file write mux select; 1 = data memory q, 0 = ALU_out.
- RF_W_Addr  output  4  register-file write address.
- RF_W_en  output  1  register-file write enable.
- RF_Ra_Addr, RF_Rb_Addr  output  4 each  register-file read addresses.
- ALU_s0  output  3  ALU function: 0 = zero, 1 = A+B, 2 = A−B.
- Illegal  output  1  see Configuration.

## Operation
- Instruction format: IR[15:12] opcode. LOAD/STORE: IR[11:4] data address, IR[3:0] register. ADD/SUB: IR[11:8] Ra, IR[7:4] Rb, IR[3:0] Rw.
- Opcodes: 0 NOOP; 1 STORE D[d]=RF[r]; 2 LOAD RF[r]=D[d]; 3 ADD RF[w]=RF[a]+RF[b]; 4 SUB RF[w]=RF[a]−RF[b]; 5 HALT.
- States: Init(0), Fetch(1), Decode(2), Noop(3), LoadA(4), LoadB(5), Store(6), Add(7), Sub(8), Halt(9).
- Init → Fetch unconditionally. Fetch → Decode. Decode → state selected by Instr_Data[15:12]; IR <= Instr_Data and PC <= PC+1 on the Decode exit edge. Noop, LoadB, Store, Add, Sub → Fetch. LoadA → LoadB. Halt → Halt until Reset.
- Outputs are Moore, decoded from state and IR; any output not listed for a state is 0.
- Store: D_Addr=IR[11:4], RF_Ra_Addr=IR[3:0], D_Wr=1.
- LoadA: D_Addr=IR[11:4] (synchronous memory read). LoadB: D_Addr=IR[11:4], RF_s=1, RF_W_Addr=IR[3:0], RF_W_en=1.
- Add: RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], ALU_s0=1, RF_s=0, RF_W_en=1. Sub identical with ALU_s0=2.
- PC increments modulo 2^PC_W; 127 → 0 with no flag.

## Timing
- Reset (async assert, sampled release): State=Init, PC_Addr=0, IR=0, all datapath outputs 0, Halted=0, Illegal=0 within the same cycle.
- Cycles per instruction: NOOP/STORE/ADD/SUB 3, LOAD 4, HALT 2 then stall.
- First fetch: PC_Addr=0 in the cycle after Init.
- RF and data-memory writes take effect on the rising edge ending the writing state; a following instruction's Fetch sees updated contents.
- Reset mid-instruction (any state, including LoadA/LoadB): abort immediately; no write enable remains asserted; no partial PC increment.
- D_Wr and RF_W_en are never high in the same cycle.

## Configuration
- CU_ILLEGAL_TRAP_EN defined: opcodes 6–15 in Decode go to Halt; Illegal=1 while halted from an illegal opcode, cleared only by Reset; Halted=1.
- Not defined: opcodes 6–15 execute as NOOP (3 cycles); Illegal tied 0.

## Test plan
- Reset mid-LoadB with RF_W_en=1 → next cycle State=0, RF_W_en=0, PC_Addr=0, IR=0.
- ROM[0]=16'h2053 (LOAD R3←D[5]) → State sequence 1,2,4,5; in LoadB D_Addr=8'h05, RF_W_Addr=3, RF_s=1, RF_W_en=1; PC_Addr=1 afterwards.
- ROM[1]=16'h1123 (STORE D[0x12]←R3) → in Store D_Addr=8'h12, RF_Ra_Addr=3, D_Wr=1, RF_W_en=0; 3 cycles total.
- ROM[2]=16'h3124, ROM[3]=16'h4124 → Add: Ra=1, Rb=2, Rw=4, ALU_s0=1, RF_s=0, RF_W_en=1; Sub identical with ALU_s0=2.
- ROM filled with NOOP → PC_Addr wraps 127 → 0; ROM[k]=16'h5000 → Halted=1, PC_Addr frozen at k+1, outputs 0 for 20+ cycles.
- ROM[0]=16'hA000 → with CU_ILLEGAL_TRAP_EN: State=9, Halted=1, Illegal=1; without: Noop executed, PC_Addr=1, Illegal=0.
